ps2_digit_decoder: RTL and testbench
====================================

Name: ps2_digit_decoder

Overview:
- Producer side of the key_valid / last_change digit interface consumed by the operand-capture FSMs.
- Takes the byte stream from the PS/2 serial receiver (scan code set 2) and tracks E0/F0 prefixes.
- Each fresh press of a digit key (main row, and the keypad when enabled) yields one key_valid pulse with the BCD digit on last_change.
- Typematic repeats, break codes, extended keys and non-digit keys produce no pulse.

Parameters:
- KEYPAD_EN, 1: 1 = keypad digits decode as well as main-row digits; 0 = main row only.
- TIMEOUT, 1000000: cycles allowed between a prefix byte and the next byte before the FSM falls back to IDLE; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rx_byte  input  8  received scan-code byte; valid only while rx_valid=1
- rx_valid  input  1  one-cycle strobe per received byte; back-to-back cycles allowed
- key_valid  output  1  one-cycle pulse for a new digit press
- last_change  output  4  BCD digit (0-9) of the most recent pulse; holds between pulses
- held_mask  output  20  [9:0] main-row digit n held; [19:10] keypad digit n held
- any_held  output  1  OR of held_mask

Behaviour:
- Reset (async, rst=1): state=IDLE, key_valid=0, last_change=4'h0, held_mask=0, any_held=0, timeout counter=0.
- Every output is registered.
- key_valid rises exactly 1 cycle after the rx_valid cycle of the completing byte, stays high 1 cycle, then returns low.
- last_change updates in the same cycle key_valid rises.
- Digit map, main row: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9.
- Digit map, keypad (no E0 prefix): 70=0, 69=1, 72=2, 7A=3, 6B=4, 73=5, 74=6, 6C=7, 75=8, 7D=9.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on rx_valid=1.
- IDLE:
  - E0 -> EXT; F0 -> BRK.
  - Digit code whose held bit is 0: set held bit, pulse key_valid, load last_change.
  - Digit code whose held bit is 1 (typematic repeat): no pulse, no change.
  - Any other byte (AA, FA, E1, 14, 77, ...): ignored, stay IDLE.
- EXT:
  - F0 -> EXT_BRK; E0 -> stay EXT.
  - Any other byte -> IDLE with no pulse. Arrow keys E0 6B / E0 72 etc. must not decode as keypad 4/2.
- BRK:
  - Digit code: clear its held bit, no pulse.
  - Any byte -> IDLE; F0 or E0 here is ignored and also returns to IDLE.
- EXT_BRK: any byte -> IDLE, no held_mask change.
- KEYPAD_EN=0: keypad codes are treated as non-digits; held_mask[19:10] stays 0.
- Simultaneous presses: each distinct physical key pulses once. Main-row 5 and keypad 5 are independent keys, so each pulses.
- Timeout: counter clears on every rx_valid and counts while state != IDLE. Reaching TIMEOUT forces IDLE; held_mask is kept.
- Reset mid-sequence (e.g. after F0): FSM returns to IDLE and held_mask clears. The next 16 counts as a fresh press.
- rx_valid with state change and a timeout expiry in the same cycle: the byte wins, and the timeout is ignored that cycle.

Test Plan:
- Reset, then bytes 16, F0, 16 -> one key_valid pulse 1 cycle after the first 16, last_change=1. held_mask[1] sets then clears; any_held ends at 0.
- Bytes 2E, 2E, 2E (typematic), F0, 2E, 2E -> exactly 2 pulses, both last_change=5.
- Bytes E0 6B, E0 F0 6B, then 6B -> no pulse for the extended arrow. Plain 6B pulses last_change=4 with KEYPAD_EN=1, and gives no pulse when rerun with KEYPAD_EN=0.
- Bytes 45 and 70 back-to-back on consecutive cycles -> pulses on the 2 following consecutive cycles, last_change=0 both times. held_mask = bit0 | bit10.
- TIMEOUT=8: byte F0, then idle 10 cycles, then 3D -> pulse with last_change=7, since the timeout returned the FSM to IDLE and 3D is a make code.
- Bytes 26 then F0, rst asserted mid-stream for 2 cycles, then 26 -> all outputs 0 during reset; 26 after reset pulses last_change=3.

Source files
------------

// File: rtl/ps2_digit_decoder.sv
// ps2_digit_decoder
//   Turns the PS/2 scan-code set 2 byte stream into one key_valid pulse per
//   fresh digit key press. It tracks the E0 (extended) and F0 (break)
//   prefixes and a per-key held mask, so that typematic repeats, releases,
//   extended keys and non-digit keys never pulse.
//
// Parameters
//   KEYPAD_EN   1 = keypad digits decode as well as main-row digits
//   TIMEOUT     idle cycles allowed after a prefix byte before the FSM
//               drops back to IDLE; 0 disables the timeout
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   rx_byte      received scan-code byte, valid while rx_valid=1
//   rx_valid     one-cycle strobe per received byte
//   key_valid    one-cycle pulse for a new digit press
//   last_change  BCD digit of the most recent pulse; holds between pulses
//   held_mask    [9:0] main-row digit n held, [19:10] keypad digit n held
//   any_held     OR of held_mask
module ps2_digit_decoder #(
   parameter bit KEYPAD_EN = 1'b1,
   parameter int TIMEOUT   = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic        key_valid,
   output logic [3:0]  last_change,
   output logic [19:0] held_mask,
   output logic        any_held
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t        state;
   logic [CW-1:0] to_cnt;

   // Byte decode: hit when the byte is a digit key; idx is its held_mask bit
   logic       hit;
   logic       kp;
   logic [3:0] digit;
   logic [4:0] idx;

   always_comb begin
      hit   = 1'b1;
      kp    = 1'b0;
      digit = 4'd0;
      case (rx_byte)
         8'h45: digit = 4'd0;
         8'h16: digit = 4'd1;
         8'h1E: digit = 4'd2;
         8'h26: digit = 4'd3;
         8'h25: digit = 4'd4;
         8'h2E: digit = 4'd5;
         8'h36: digit = 4'd6;
         8'h3D: digit = 4'd7;
         8'h3E: digit = 4'd8;
         8'h46: digit = 4'd9;
         8'h70: begin kp = 1'b1; digit = 4'd0; end
         8'h69: begin kp = 1'b1; digit = 4'd1; end
         8'h72: begin kp = 1'b1; digit = 4'd2; end
         8'h7A: begin kp = 1'b1; digit = 4'd3; end
         8'h6B: begin kp = 1'b1; digit = 4'd4; end
         8'h73: begin kp = 1'b1; digit = 4'd5; end
         8'h74: begin kp = 1'b1; digit = 4'd6; end
         8'h6C: begin kp = 1'b1; digit = 4'd7; end
         8'h75: begin kp = 1'b1; digit = 4'd8; end
         8'h7D: begin kp = 1'b1; digit = 4'd9; end
         default: hit = 1'b0;
      endcase
      if (kp && !KEYPAD_EN) hit = 1'b0;
      idx = kp ? 5'd10 + {1'b0, digit} : {1'b0, digit};
   end

   // Only a byte arriving with no prefix pending can press a key, and only
   // a byte after a plain F0 can release one.
   logic        press;
   logic [19:0] held_next;

   always_comb begin
      press     = rx_valid && (state == IDLE) && hit && !held_mask[idx];
      held_next = held_mask;
      if (press) held_next[idx] = 1'b1;
      if (rx_valid && (state == BRK) && hit) held_next[idx] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         to_cnt      <= '0;
         key_valid   <= 1'b0;
         last_change <= 4'h0;
         held_mask   <= '0;
         any_held    <= 1'b0;
      end else begin
         key_valid <= press;
         held_mask <= held_next;
         any_held  <= |held_next;
         if (press) last_change <= digit;

         if (rx_valid) begin
            // A byte always takes priority over a timeout expiring this cycle
            to_cnt <= '0;
            case (state)
               IDLE:    if (rx_byte == 8'hE0)      state <= EXT;
                        else if (rx_byte == 8'hF0) state <= BRK;
               EXT:     if (rx_byte == 8'hF0)      state <= EXT_BRK;
                        else if (rx_byte != 8'hE0) state <= IDLE;
               BRK:     state <= IDLE;
               EXT_BRK: state <= IDLE;
               default: state <= IDLE;
            endcase
         end else if (state != IDLE && TIMEOUT != 0) begin
            if (to_cnt == TO_LAST) begin
               state  <= IDLE;
               to_cnt <= '0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_digit_decoder.sv
// Bench for ps2_digit_decoder: two instances (keypad enabled / disabled,
// both with a short timeout) driven by the same byte stream and compared
// every cycle against a prefix-queue reference model.
module tb_ps2_digit_decoder;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;

   logic        key_valid_kp, key_valid_nk;
   logic [3:0]  last_change_kp, last_change_nk;
   logic [19:0] held_mask_kp, held_mask_nk;
   logic        any_held_kp, any_held_nk;

   always #5 clk = ~clk;

   ps2_digit_decoder #(.KEYPAD_EN(1'b1), .TIMEOUT(TO)) dut_kp (
      .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .key_valid(key_valid_kp), .last_change(last_change_kp),
      .held_mask(held_mask_kp), .any_held(any_held_kp));

   ps2_digit_decoder #(.KEYPAD_EN(1'b0), .TIMEOUT(TO)) dut_nk (
      .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .key_valid(key_valid_nk), .last_change(last_change_nk),
      .held_mask(held_mask_nk), .any_held(any_held_nk));

   int total = 0;
   int bad   = 0;
   int pulses = 0;

   // Reference model: prefix bytes seen since the last completed code,
   // plus per-instance held set and last pulse. Index 1 = keypad enabled.
   logic [7:0]  pend[$];
   int          idle;
   logic        exp_kv[2];
   logic [3:0]  exp_lc[2];
   logic [19:0] exp_held[2];
   logic [7:0]  main_code[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [7:0]  pad_code[10]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                  8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

   function automatic int key_of(input logic [7:0] b, input int kp_en);
      int k = -1;
      for (int i = 0; i < 10; i++) begin
         if (main_code[i] == b) k = i;
         if (kp_en != 0 && pad_code[i] == b) k = 10 + i;
      end
      return k;
   endfunction

   task automatic model_reset();
      pend.delete();
      idle = 0;
      for (int m = 0; m < 2; m++) begin
         exp_kv[m] = 1'b0; exp_lc[m] = 4'h0; exp_held[m] = '0;
      end
   endtask

   task automatic model_clock(input bit v, input logic [7:0] b);
      int k;
      for (int m = 0; m < 2; m++) exp_kv[m] = 1'b0;
      if (v) begin
         idle = 0;
         if (pend.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0) pend.push_back(b);
            else for (int m = 0; m < 2; m++) begin
               k = key_of(b, m);
               if (k >= 0 && !exp_held[m][k]) begin
                  exp_held[m][k] = 1'b1;
                  exp_kv[m] = 1'b1;
                  exp_lc[m] = 4'(k % 10);
               end
            end
         end else if (pend.size() == 1 && pend[0] == 8'hE0) begin
            if (b == 8'hF0) pend.push_back(b);
            else if (b != 8'hE0) pend.delete();
         end else if (pend.size() == 1 && pend[0] == 8'hF0) begin
            for (int m = 0; m < 2; m++) begin
               k = key_of(b, m);
               if (k >= 0) exp_held[m][k] = 1'b0;
            end
            pend.delete();
         end else begin
            pend.delete();
         end
      end else if (pend.size() != 0) begin
         idle++;
         if (idle == TO) begin
            pend.delete();
            idle = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare(input string tag);
      chk({tag, " kv_kp"},   32'(key_valid_kp),   32'(exp_kv[1]));
      chk({tag, " lc_kp"},   32'(last_change_kp), 32'(exp_lc[1]));
      chk({tag, " held_kp"}, 32'(held_mask_kp),   32'(exp_held[1]));
      chk({tag, " any_kp"},  32'(any_held_kp),    32'(exp_held[1] != 0));
      chk({tag, " kv_nk"},   32'(key_valid_nk),   32'(exp_kv[0]));
      chk({tag, " lc_nk"},   32'(last_change_nk), 32'(exp_lc[0]));
      chk({tag, " held_nk"}, 32'(held_mask_nk),   32'(exp_held[0]));
      chk({tag, " any_nk"},  32'(any_held_nk),    32'(exp_held[0] != 0));
   endtask

   // One clock: present (v, b) for exactly one rising edge, then check
   task automatic step(input bit v, input logic [7:0] b, input string tag);
      @(negedge clk);
      rx_valid = v;
      rx_byte  = b;
      @(posedge clk);
      model_clock(v, b);
      #1;
      if (key_valid_kp) pulses++;
      compare(tag);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, tag);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rx_valid = 1'b0;
      rst = 1'b1;
      #1;
      model_reset();
      compare("rst_async");
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         compare("rst_hold");
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   logic [7:0] pool[26] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                            8'h3D, 8'h3E, 8'h46, 8'h70, 8'h69, 8'h72, 8'h7A,
                            8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D, 8'hE0,
                            8'hF0, 8'hAA, 8'h14, 8'hFA, 8'h77};

   initial begin
      logic [7:0] b;
      int r;
      model_reset();
      do_reset(2);

      // press / release of main-row 1
      step(1'b1, 8'h16, "press1");
      chk("press1 pulse", 32'(key_valid_kp), 32'd1);
      chk("press1 digit", 32'(last_change_kp), 32'd1);
      chk("press1 held", 32'(held_mask_kp), 32'h2);
      step(1'b0, 8'h00, "press1_gap");
      chk("press1 one_cycle", 32'(key_valid_kp), 32'd0);
      step(1'b1, 8'hF0, "brk1_f0");
      step(1'b1, 8'h16, "brk1");
      chk("brk1 any_held", 32'(any_held_kp), 32'd0);

      // typematic repeats of 5
      pulses = 0;
      step(1'b1, 8'h2E, "rep5");
      step(1'b1, 8'h2E, "rep5");
      step(1'b1, 8'h2E, "rep5");
      step(1'b1, 8'hF0, "rep5_f0");
      step(1'b1, 8'h2E, "rep5_brk");
      step(1'b1, 8'h2E, "rep5_again");
      chk("rep5 pulses", 32'(pulses), 32'd2);
      chk("rep5 digit", 32'(last_change_kp), 32'd5);
      step(1'b1, 8'hF0, "rel5_f0");
      step(1'b1, 8'h2E, "rel5");

      // extended arrow vs keypad 4
      pulses = 0;
      step(1'b1, 8'hE0, "arrow");
      step(1'b1, 8'h6B, "arrow");
      step(1'b1, 8'hE0, "arrow_brk");
      step(1'b1, 8'hF0, "arrow_brk");
      step(1'b1, 8'h6B, "arrow_brk");
      chk("arrow no_pulse", 32'(pulses), 32'd0);
      step(1'b1, 8'h6B, "kp4");
      chk("kp4 pulse", 32'(key_valid_kp), 32'd1);
      chk("kp4 digit", 32'(last_change_kp), 32'd4);
      chk("kp4 disabled", 32'(key_valid_nk), 32'd0);
      step(1'b1, 8'hF0, "kp4_rel");
      step(1'b1, 8'h6B, "kp4_rel");

      // main-row 0 and keypad 0 back to back
      step(1'b1, 8'h45, "zero_main");
      chk("zero_main pulse", 32'(key_valid_kp), 32'd1);
      step(1'b1, 8'h70, "zero_pad");
      chk("zero_pad pulse", 32'(key_valid_kp), 32'd1);
      chk("zero_pad digit", 32'(last_change_kp), 32'd0);
      chk("zero held", 32'(held_mask_kp), 32'h401);
      chk("zero held_nk", 32'(held_mask_nk), 32'h001);

      // timeout after a lone F0
      step(1'b1, 8'hF0, "to_f0");
      idle_cycles(10, "to_idle");
      step(1'b1, 8'h3D, "to_make7");
      chk("to_make7 pulse", 32'(key_valid_kp), 32'd1);
      chk("to_make7 digit", 32'(last_change_kp), 32'd7);

      // byte arriving on the very cycle the timeout would fire
      step(1'b1, 8'hF0, "to_edge_f0");
      idle_cycles(TO - 1, "to_edge_idle");
      step(1'b1, 8'h3D, "to_edge_brk");
      chk("to_edge released", 32'(held_mask_kp[7]), 32'd0);

      // reset mid-sequence
      step(1'b1, 8'h26, "rst_mid");
      step(1'b1, 8'hF0, "rst_mid_f0");
      do_reset(2);
      step(1'b1, 8'h26, "after_rst");
      chk("after_rst pulse", 32'(key_valid_kp), 32'd1);
      chk("after_rst digit", 32'(last_change_kp), 32'd3);

      // randomized byte stream with random gaps
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         if (r < 20)      b = 8'hF0;
         else if (r < 28) b = 8'hE0;
         else if (r < 31) b = 8'($urandom);
         else             b = pool[$urandom_range(0, 25)];
         step(1'b1, b, "rand");
         if ($urandom_range(0, 9) < 3) idle_cycles($urandom_range(1, 11), "rand_gap");
         if (n == 300) do_reset(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
